// File: rtl/serial_sub4_full_sub.sv
`default_nettype none
// ============================================================================
// Module   : full_sub
// Purpose  : 1-bit full subtractor, the single arithmetic stage that the
//            bit-serial subtractor reuses on every cycle.
// Ports    : x   - minuend bit
//            y   - subtrahend bit
//            bi  - borrow in
//            d   - difference bit  (x - y - bi) mod 2
//            bo  - borrow out      (x < y + bi)
// Revision : 1.0 - initial release
// ============================================================================
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // A borrow is needed when y + bi exceeds x.
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule
`default_nettype wire

// File: rtl/serial_sub4.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub4
// Purpose  : Bit-serial unsigned subtractor, diff = a - b - bin, one bit per
//            clock (LSB first) through a single 1-bit full subtractor with the
//            borrow registered between bits.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous active-high reset
//            start - request strobe, sampled only while idle
//            a     - minuend      (sampled with start)
//            b     - subtrahend   (sampled with start)
//            bin   - borrow in    (sampled with start)
//            busy  - high while bits are being computed
//            done  - one-cycle pulse, diff/bout valid from this cycle
//            diff  - difference, held until the next done
//            bout  - borrow out, held until the next done
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             w_d;
  logic             w_bo;

  // Operands are shifted right every bit-cycle, so the current bit is
  // always at position 0.
  full_sub u_full_sub (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (brw_q),
    .d  (w_d),
    .bo (w_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end

      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = w_bo;
        // New bit enters at the MSB; after WIDTH shifts the first (LSB)
        // bit has arrived at position 0.
        res_d = (res_q >> 1) | ({{(WIDTH-1){1'b0}}, w_d} << (WIDTH - 1));
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          // Outputs are loaded together with the final bit so they are
          // already valid during the done cycle and never show partials.
          diff_d  = res_d;
          bout_d  = w_bo;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub4.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub4
// Purpose  : Self-checking bench for serial_sub4: vector table, hand-written
//            multi-cycle sequences and a full operand sweep, with expected
//            results queued at stimulus time and popped on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  always #5 clk = ~clk;

  serial_sub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  typedef struct {
    logic [W:0] res;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];

  int checks    = 0;
  int fails     = 0;
  int sweep_ok  = 0;
  int sweep_bad = 0;
  bit in_sweep  = 1'b0;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic bi);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done with diff=%0d bout=%0b, required no done pulse",
                 diff, bout);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if ({bout, diff} !== mon_e.res) begin
          fails++;
          if (in_sweep) sweep_bad++;
          $display("FAIL result[%0d]: got bout=%0b diff=%0d, required bout=%0b diff=%0d",
                   mon_e.tag, bout, diff, mon_e.res[W], mon_e.res[W-1:0]);
        end else if (in_sweep) begin
          sweep_ok++;
        end
      end
    end
  end

  // One request: queue the expectation, pulse start, scramble the operand
  // inputs afterwards, then wait (bounded) for the done pulse.
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                       input logic [W:0] exp, input int tag);
    bit seen;
    seen = 1'b0;
    sb_q.push_back('{exp, tag});
    @(negedge clk);
    start = 1'b1; a = va; b = vb; bin = vbin;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout[%0d]: got no done in 12 cycles, required a done pulse", tag);
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int done_at;
    int dcount;
    int nd;
    int t[3];
    bit stable_ok;
    logic [W-1:0] prev_diff;

    vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    vecs[4] = '{4'd9,  4'd4,  1'b0, 4'd5,  1'b0};
    vecs[5] = '{4'd7,  4'd1,  1'b0, 4'd6,  1'b0};
    vecs[6] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
    vecs[7] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    rst = 1'b0;

    // Latency, busy width and absence of partial results (5 - 3 - 0).
    sb_q.push_back('{5'b00010, 0});
    @(negedge clk);
    start = 1'b1; a = 4'd5; b = 4'd3; bin = 1'b0;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    busy_cnt = 0; done_at = 0; stable_ok = 1'b1; prev_diff = diff;
    for (int k = 1; k <= 10; k++) begin
      if (busy) begin
        busy_cnt++;
        if (diff !== prev_diff) stable_ok = 1'b0;
      end
      if (done && done_at == 0) done_at = k;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 4);
    check("done_latency", done_at, 5);
    check("no_partial_result", stable_ok, 1);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].bout, vecs[i].diff}, 10 + i);
    end

    // Second start while busy is ignored.
    sb_q.push_back('{5'b00101, 31});
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd4; bin = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd1; b = 4'd2; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("single_done", dcount, 1);

    // Reset mid-operation aborts it; reset also wins over start.
    @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd1; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("abort_no_done", dcount, 0);
    do_op(4'd7, 4'd1, 1'b0, 5'b00110, 32);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    repeat (3) sb_q.push_back('{5'b00100, 40});
    @(negedge clk);
    start = 1'b1; a = 4'd12; b = 4'd7; bin = 1'b1;
    nd = 0;
    for (int k = 1; k <= 40 && nd < 3; k++) begin
      @(negedge clk);
      if (done) begin
        t[nd] = k;
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_count", nd, 3);
    check("b2b_period_1", t[1] - t[0], W + 2);
    check("b2b_period_2", t[2] - t[1], W + 2);
    repeat (3) @(negedge clk);

    // Exhaustive sweep.
    in_sweep = 1'b1;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          do_op(W'(ia), W'(ib), 1'(ic), model(W'(ia), W'(ib), 1'(ic)),
                1000 + ia * 32 + ib * 2 + ic);
        end
      end
    end
    @(negedge clk);
    in_sweep = 1'b0;
    $display("sweep totals: %0d correct, %0d incorrect", sweep_ok, sweep_bad);
    check("sweep_correct", sweep_ok, 512);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
